uart_rx_top: RTL

UART_RX_TOP -- requirements
Module: uart_rx_top

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_top.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, oversampling constants and
// parity/alignment helpers used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 7;

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(HALF_BIT);

    // Expected parity bit as selected by {stick parity, even parity select}.
    function automatic logic expected_parity(input logic [7:0] data,
                                             input logic       sticky,
                                             input logic       even);
        case ({sticky, even})
            2'b00:   return ~^data;
            2'b01:   return ^data;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] align_word(input logic [7:0] shift,
                                              input logic [1:0] wls);
        return shift >> (2'd3 - wls);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: line, baud enable, LCR controls and the
// word/status output toward the RX FIFO.
interface uart_rx_if;

    logic       baud_pulse;
    logic       rx;
    logic       pen;
    logic       eps;
    logic       sticky_parity;
    logic [1:0] wls;
    logic [7:0] dout;
    logic       push;
    logic       pe;
    logic       fe;
    logic       bi;

    modport master (
        output baud_pulse, rx, pen, eps, sticky_parity, wls,
        input  dout, push, pe, fe, bi
    );

    modport slave (
        input  baud_pulse, rx, pen, eps, sticky_parity, wls,
        output dout, push, pe, fe, bi
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit with a
// configurable reset value.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// 16x oversampling UART receiver: 5-8 data bits, optional (sticky) parity,
// framing and break detection, one push per completed frame.
module uart_rx_top
    import uart_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    logic rx_s;

    uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    uart_state_e state, state_n;
    logic [3:0]  count, count_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic        armed, armed_n;
    logic [7:0]  shift, shift_n;
    logic [1:0]  wls_l, wls_l_n;
    logic        pen_l, pen_l_n;
    logic        eps_l, eps_l_n;
    logic        stick_l, stick_l_n;
    logic        par_bit, par_bit_n;
    logic        pe_pend, pe_pend_n;
    logic [7:0]  dout_r, dout_n;
    logic        push_r, push_n;
    logic        pe_r, pe_n;
    logic        fe_r, fe_n;
    logic        bi_r, bi_n;
    logic [7:0]  word;

    assign word = align_word(shift, wls_l);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            bitcnt  <= '0;
            armed   <= 1'b0;
            shift   <= '0;
            wls_l   <= '0;
            pen_l   <= 1'b0;
            eps_l   <= 1'b0;
            stick_l <= 1'b0;
            par_bit <= 1'b0;
            pe_pend <= 1'b0;
            dout_r  <= '0;
            push_r  <= 1'b0;
            pe_r    <= 1'b0;
            fe_r    <= 1'b0;
            bi_r    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            bitcnt  <= bitcnt_n;
            armed   <= armed_n;
            shift   <= shift_n;
            wls_l   <= wls_l_n;
            pen_l   <= pen_l_n;
            eps_l   <= eps_l_n;
            stick_l <= stick_l_n;
            par_bit <= par_bit_n;
            pe_pend <= pe_pend_n;
            dout_r  <= dout_n;
            push_r  <= push_n;
            pe_r    <= pe_n;
            fe_r    <= fe_n;
            bi_r    <= bi_n;
        end
    end

    // Everything advances only on baud ticks; push alone self-clears every clk.
    always_comb begin
        state_n   = state;
        count_n   = count;
        bitcnt_n  = bitcnt;
        armed_n   = armed;
        shift_n   = shift;
        wls_l_n   = wls_l;
        pen_l_n   = pen_l;
        eps_l_n   = eps_l;
        stick_l_n = stick_l;
        par_bit_n = par_bit;
        pe_pend_n = pe_pend;
        dout_n    = dout_r;
        push_n    = 1'b0;
        pe_n      = pe_r;
        fe_n      = fe_r;
        bi_n      = bi_r;

        if (bus.baud_pulse) begin
            case (state)
                IDLE: begin
                    if (!rx_s && armed) begin
                        state_n   = START;
                        count_n   = MID_TICK;
                        armed_n   = 1'b0;
                        wls_l_n   = bus.wls;
                        pen_l_n   = bus.pen;
                        eps_l_n   = bus.eps;
                        stick_l_n = bus.sticky_parity;
                        par_bit_n = 1'b0;
                        pe_pend_n = 1'b0;
                    end else if (rx_s) begin
                        armed_n = 1'b1;
                    end
                end
                START: begin
                    if (count != 4'd0) begin
                        count_n = count - 4'd1;
                    end else if (!rx_s) begin
                        state_n  = DATA;
                        count_n  = LAST_TICK;
                        bitcnt_n = {1'b1, wls_l};
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    if (count != 4'd0) begin
                        count_n = count - 4'd1;
                    end else begin
                        shift_n = {rx_s, shift[7:1]};
                        count_n = LAST_TICK;
                        if (bitcnt == 3'd0) begin
                            state_n = pen_l ? PARITY : STOP;
                        end else begin
                            bitcnt_n = bitcnt - 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (count != 4'd0) begin
                        count_n = count - 4'd1;
                    end else begin
                        par_bit_n = rx_s;
                        pe_pend_n = rx_s != expected_parity(word, stick_l, eps_l);
                        count_n   = LAST_TICK;
                        state_n   = STOP;
                    end
                end
                STOP: begin
                    if (count != 4'd0) begin
                        count_n = count - 4'd1;
                    end else begin
                        dout_n  = word;
                        pe_n    = pe_pend;
                        fe_n    = ~rx_s;
                        bi_n    = (word == 8'd0) && !rx_s && (!par_bit || !pen_l);
                        push_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.dout = dout_r;
    assign bus.push = push_r;
    assign bus.pe   = pe_r;
    assign bus.fe   = fe_r;
    assign bus.bi   = bi_r;

endmodule
